// File: rtl/sync_sp_ram_tiled_if.sv
// Request/response bundle for sync_sp_ram_tiled: one access per cycle,
// read data returned with a single-cycle valid strobe.
interface sync_sp_ram_tiled_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
);
    localparam int BE_W = (DATA_WIDTH + 7) / 8;

    logic                  CSel_SI;
    logic                  WrEn_SI;
    logic [BE_W-1:0]       BEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_DI;
    logic [DATA_WIDTH-1:0] WrData_DI;
    logic                  Ready_SO;
    logic                  RdValid_SO;
    logic [DATA_WIDTH-1:0] RdData_DO;

    modport master (
        output CSel_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
        input  Ready_SO, RdValid_SO, RdData_DO
    );

    modport slave (
        input  CSel_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
        output Ready_SO, RdValid_SO, RdData_DO
    );
endinterface

// File: rtl/sync_sp_ram_tiled.sv
// Single-port RAM built from a ROWS x COLS grid of 256x16 bit-masked tiles,
// with a post-reset zero-fill sweep and 1- or 2-cycle registered reads.
module sync_sp_ram_tiled #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    sync_sp_ram_tiled_if.slave    bus
);
    localparam int COLS   = (DATA_WIDTH + 15) / 16;
    localparam int ROWS   = 1 << (ADDR_WIDTH - 8);
    localparam int PAD_W  = COLS * 16;
    localparam int RSEL_W = (ADDR_WIDTH > 8) ? ADDR_WIDTH - 8 : 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic ready;
    logic sweep;
    logic accept;
    logic rd_accept;
    logic rd_valid_reg;

    logic [RSEL_W-1:0]            row_sel;
    logic [ROWS-1:0]              row_ce_n;
    logic                         mac_we_n;
    logic [7:0]                   mac_addr;
    logic [PAD_W-1:0]             mac_mask;
    logic [PAD_W-1:0]             mac_wd;
    logic [PAD_W-1:0]             run_mask;
    logic [PAD_W-1:0]             wr_pad;
    logic [ROWS-1:0][PAD_W-1:0]   row_q;
    logic [PAD_W-1:0]             rd_row;
    logic [DATA_WIDTH-1:0]        rd_word;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_reg <= (INIT_EN != 0) ? S_INIT : S_RUN;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_INIT: begin
                cnt_next = cnt_reg + 8'd1;
                if (cnt_reg == 8'hFF) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                state_next = S_RUN;
            end
            default: state_next = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = 1'b0;
        sweep = 1'b0;
        case (state_reg)
            S_INIT:  sweep = 1'b1;
            S_RUN:   ready = 1'b1;
            default: sweep = 1'b0;
        endcase
    end

    assign bus.Ready_SO = ready;
    // Tile accesses are suppressed while reset is held so no stray write lands.
    assign accept       = bus.CSel_SI && ready && Rst_RBI;
    assign rd_accept    = accept && !bus.WrEn_SI;
    assign wr_pad       = PAD_W'(bus.WrData_DI);

    genvar gi, gj;

    // Per-bit write mask: pad bits beyond DATA_WIDTH are never written in RUN.
    generate
        for (gi = 0; gi < PAD_W; gi++) begin : g_mask
            if (gi < DATA_WIDTH) begin : g_data
                assign run_mask[gi] = bus.BEn_SI[gi/8];
            end else begin : g_pad
                assign run_mask[gi] = 1'b0;
            end
        end
    endgenerate

    // Address split and row select register (absent when there is one row).
    generate
        if (ADDR_WIDTH > 8) begin : g_multi_row
            logic [RSEL_W-1:0] row_sel_reg;
            assign row_sel = bus.Addr_DI[ADDR_WIDTH-1:8];
            always_ff @(posedge Clk_CI) begin
                if (!Rst_RBI) begin
                    row_sel_reg <= '0;
                end else if (rd_accept) begin
                    row_sel_reg <= row_sel;
                end
            end
            assign rd_row = row_q[row_sel_reg];
        end else begin : g_single_row
            assign row_sel = '0;
            assign rd_row  = row_q[0];
        end
    endgenerate

    // Tile control: active-low chip enable per row, shared we/addr/mask/data.
    always_comb begin
        row_ce_n = '1;
        mac_we_n = 1'b1;
        mac_addr = bus.Addr_DI[7:0];
        mac_mask = run_mask;
        mac_wd   = wr_pad;
        if (sweep && Rst_RBI) begin
            row_ce_n = '0;
            mac_we_n = 1'b0;
            mac_addr = cnt_reg;
            mac_mask = '1;
            mac_wd   = '0;
        end else if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_sel == RSEL_W'(r)) begin
                    row_ce_n[r] = 1'b0;
                end
            end
            mac_we_n = !bus.WrEn_SI;
        end
    end

    // Tile grid: each tile is a 256x16 array with bit-masked write and registered read.
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic [15:0] mem [256];
                logic [15:0] q_reg;

                always_ff @(posedge Clk_CI) begin
                    if (!row_ce_n[gi]) begin
                        if (!mac_we_n) begin
                            for (int b = 0; b < 16; b++) begin
                                if (mac_mask[16*gj+b]) begin
                                    mem[mac_addr][b] <= mac_wd[16*gj+b];
                                end
                            end
                        end else begin
                            q_reg <= mem[mac_addr];
                        end
                    end
                end

                assign row_q[gi][16*gj +: 16] = q_reg;
            end
        end
    endgenerate

    assign rd_word = rd_row[DATA_WIDTH-1:0];

    generate
        if (PAD_W > DATA_WIDTH) begin : g_pad_discard
            logic unused_pad;
            assign unused_pad = ^rd_row[PAD_W-1:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
        end
    end

    // Output stage: gated combinational data, or a load-on-valid holding register.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  out_valid_reg;
            logic [DATA_WIDTH-1:0] out_data_reg;
            always_ff @(posedge Clk_CI) begin
                if (!Rst_RBI) begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                end else begin
                    out_valid_reg <= rd_valid_reg;
                    if (rd_valid_reg) begin
                        out_data_reg <= rd_word;
                    end
                end
            end
            assign bus.RdValid_SO = out_valid_reg;
            assign bus.RdData_DO  = out_data_reg;
        end else begin : g_out_comb
            assign bus.RdValid_SO = rd_valid_reg;
            assign bus.RdData_DO  = rd_valid_reg ? rd_word : '0;
        end
    endgenerate
endmodule
